// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: register offsets, key sequencer states and irq bit indices
package aes_ctrl_pkg;
  localparam logic [4:0] REG_CTRL    = 5'd0;
  localparam logic [4:0] REG_CMD     = 5'd1;
  localparam logic [4:0] REG_IRQ_STS = 5'd2;
  localparam logic [4:0] REG_IRQ_EN  = 5'd3;
  localparam logic [4:0] REG_KEY0    = 5'd4;
  localparam logic [4:0] REG_KEY1    = 5'd5;
  localparam logic [4:0] REG_KEY2    = 5'd6;
  localparam logic [4:0] REG_KEY3    = 5'd7;
  localparam logic [4:0] REG_IV0     = 5'd8;
  localparam logic [4:0] REG_IV1     = 5'd9;
  localparam logic [4:0] REG_IV2     = 5'd10;
  localparam logic [4:0] REG_IV3     = 5'd11;
  typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_WAIT = 3'd2} state_t;
  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;
  localparam int IRQ_TMO  = 2;
endpackage

// File: rtl/aes_ctrl_regs.sv
// aes_ctrl_regs: AES control/status registers with serial key loader and maskable irq
module aes_ctrl_regs
  import aes_ctrl_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [C_ADDR_WIDTH-1:0] reg_data_addr,
  input  logic                    reg_data_write,
  input  logic [C_DATA_WIDTH-1:0] reg_data,
  input  logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    aes_enable,
  output logic                    aes_decrypt,
  output logic [127:0]            aes_iv,
  output logic [31:0]             key_word,
  output logic                    key_valid,
  input  logic                    key_ready,
  input  logic                    key_done,
  output logic                    irq,
  output logic [31:0]             aes_sts_dbg
);
  localparam int TW = $clog2(C_TIMEOUT);
  state_t state;
  logic [1:0] ctrl, idx;
  logic [2:0] sts, en, sts_set, sts_clr;
  logic [7:0] cnt;
  logic [TW-1:0] tcnt;
  logic [31:0] key_r [4];
  logic [31:0] iv_r [4];
  logic [4:0] wa, ra;
  logic busy, start, key_wr, tmo, unused;
  logic [C_DATA_WIDTH-1:0] rd_mux;
  assign wa = reg_data_addr[6:2];
  assign ra = rd_addr[6:2];
  assign unused = ^{reg_data_addr[C_ADDR_WIDTH-1:7], reg_data_addr[1:0], rd_addr[C_ADDR_WIDTH-1:7], rd_addr[1:0]};
  assign aes_enable = ctrl[0];
  assign aes_decrypt = ctrl[1];
  assign aes_iv = {iv_r[3], iv_r[2], iv_r[1], iv_r[0]};
  assign key_word = key_r[idx];
  assign aes_sts_dbg = {16'h0, cnt, 2'b0, sts, state};
  always_comb begin
    busy = state != ST_IDLE;
    start = reg_data_write && wa == REG_CMD && reg_data[0];
    key_wr = reg_data_write && wa >= REG_KEY0 && wa <= REG_KEY3;
    tmo = state == ST_WAIT && !key_done && tcnt == TW'(C_TIMEOUT - 1);
    sts_set = '0;
    sts_set[IRQ_DONE] = state == ST_WAIT && key_done;
    sts_set[IRQ_ERR] = busy && (start || key_wr);
    sts_set[IRQ_TMO] = tmo;
    sts_clr = reg_data_write && wa == REG_IRQ_STS ? reg_data[2:0] : 3'b0;
    rd_mux = ra == REG_CTRL ? {30'b0, ctrl} :
             ra == REG_IRQ_STS ? {29'b0, sts} :
             ra == REG_IRQ_EN ? {29'b0, en} :
             (ra >= REG_KEY0 && ra <= REG_KEY3) ? key_r[ra[1:0]] :
             (ra >= REG_IV0 && ra <= REG_IV3) ? iv_r[ra[1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ctrl <= '0;
      idx <= '0;
      sts <= '0;
      en <= '0;
      cnt <= '0;
      tcnt <= '0;
      key_r <= '{default: '0};
      iv_r <= '{default: '0};
      rd_data <= '0;
      irq <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      if (reg_data_write && wa == REG_CTRL) ctrl <= reg_data[1:0];
      if (reg_data_write && wa == REG_IRQ_EN) en <= reg_data[2:0];
      if (key_wr && !busy) key_r[wa[1:0]] <= reg_data;
      if (reg_data_write && wa >= REG_IV0 && wa <= REG_IV3) iv_r[wa[1:0]] <= reg_data;
      sts <= (sts & ~sts_clr) | sts_set;
      irq <= |(sts & en);
      rd_data <= rd_mux;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_LOAD;
          idx <= '0;
          key_valid <= 1'b1;
        end
        ST_LOAD: if (key_ready) begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= ST_WAIT;
            key_valid <= 1'b0;
            tcnt <= '0;
          end
        end
        ST_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (key_done) begin
            state <= ST_IDLE;
            cnt <= cnt + 8'd1;
          end else if (tmo) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          key_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_ctrl_regs.sv
// tb_aes_ctrl_regs: randomized self-checking bench against a register-map model
module tb_aes_ctrl_regs;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] reg_data_addr = '0;
  logic reg_data_write = 1'b0;
  logic [31:0] reg_data = '0;
  logic [9:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic aes_enable, aes_decrypt;
  logic [127:0] aes_iv;
  logic [31:0] key_word;
  logic key_valid;
  logic key_ready = 1'b0;
  logic key_done = 1'b0;
  logic irq;
  logic [31:0] aes_sts_dbg;
  int tests = 0;
  int fails = 0;
  logic [1:0] ctrl_m;
  logic [2:0] sts_m, en_m;
  logic [7:0] cnt_m;
  logic [31:0] key_m [4];
  logic [31:0] iv_m [4];
  bit m_busy;
  int hs_n, unstable_n, cyc_n;
  logic [31:0] obs_w [4];

  aes_ctrl_regs #(.C_ADDR_WIDTH(10), .C_DATA_WIDTH(32), .C_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .reg_data_addr(reg_data_addr), .reg_data_write(reg_data_write),
    .reg_data(reg_data), .rd_addr(rd_addr), .rd_data(rd_data), .aes_enable(aes_enable),
    .aes_decrypt(aes_decrypt), .aes_iv(aes_iv), .key_word(key_word), .key_valid(key_valid),
    .key_ready(key_ready), .key_done(key_done), .irq(irq), .aes_sts_dbg(aes_sts_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task m_reset;
    ctrl_m = '0; sts_m = '0; en_m = '0; cnt_m = '0; m_busy = 0;
    for (int i = 0; i < 4; i++) begin key_m[i] = '0; iv_m[i] = '0; end
  endtask

  task model_wr(input logic [9:0] a, input logic [31:0] d);
    int o;
    o = int'(a[6:2]);
    if (o == 0) ctrl_m = d[1:0];
    else if (o == 1 && d[0]) begin if (m_busy) sts_m[1] = 1'b1; else m_busy = 1; end
    else if (o == 2) sts_m = sts_m & ~d[2:0];
    else if (o == 3) en_m = d[2:0];
    else if (o >= 4 && o <= 7) begin if (m_busy) sts_m[1] = 1'b1; else key_m[o-4] = d; end
    else if (o >= 8 && o <= 11) iv_m[o-8] = d;
  endtask

  function automatic logic [31:0] m_read(input logic [9:0] a);
    int o;
    o = int'(a[6:2]);
    if (o == 0) return {30'b0, ctrl_m};
    if (o == 2) return {29'b0, sts_m};
    if (o == 3) return {29'b0, en_m};
    if (o >= 4 && o <= 7) return key_m[o-4];
    if (o >= 8 && o <= 11) return iv_m[o-8];
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_dbg(input logic [2:0] st);
    return {16'h0, cnt_m, 2'b0, sts_m, st};
  endfunction

  task wr(input logic [9:0] a, input logic [31:0] d);
    reg_data_addr = a; reg_data = d; reg_data_write = 1'b1;
    model_wr(a, d);
    tick;
    reg_data_write = 1'b0;
  endtask

  task rd(input logic [9:0] a, output logic [31:0] d);
    rd_addr = a;
    tick;
    d = rd_data;
  endtask

  task do_load(input int mode);
    logic r, prev_stall;
    logic [31:0] prev_word;
    hs_n = 0; unstable_n = 0; cyc_n = 0; prev_stall = 0; prev_word = '0;
    for (int c = 0; c < 64 && hs_n < 4; c++) begin
      r = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom % 2);
      key_ready = r;
      if (prev_stall && (key_word !== prev_word || key_valid !== 1'b1)) unstable_n++;
      if (key_valid && r) begin obs_w[hs_n] = key_word; hs_n++; end
      prev_stall = key_valid && !r;
      prev_word = key_word;
      tick;
      cyc_n++;
    end
    key_ready = 1'b0;
  endtask

  task finish_done;
    key_done = 1'b1;
    tick;
    key_done = 1'b0;
    m_busy = 0; sts_m[0] = 1'b1; cnt_m++;
  endtask

  task test_reset;
    logic [31:0] d;
    reset = 1'b1; tick; tick; reset = 1'b0;
    m_reset;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    tests++; if (aes_sts_dbg !== 32'h0) begin fails++; $display("FAIL reset_dbg: got %h expected 0", aes_sts_dbg); end
    tests++; if (rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    for (int a = 0; a < 64; a += 4) begin
      rd(10'(a), d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_read[%h]: got %h expected 0", a, d); end
    end
  endtask

  task test_ctrl_rw;
    logic [31:0] d, x;
    logic [9:0] a;
    wr(10'h000, 32'h3);
    tests++; if (aes_enable !== 1'b1 || aes_decrypt !== 1'b1) begin fails++; $display("FAIL ctrl_bits: got %b%b expected 11", aes_decrypt, aes_enable); end
    rd(10'h000, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL ctrl_readback: got %h expected 3", d); end
    for (int i = 0; i < 30; i++) begin
      a = 10'($urandom);
      x = $urandom;
      if (a[6:2] == 5'd1) x[0] = 1'b0;
      wr(a, x);
      a = 10'($urandom_range(0, 15) * 4);
      rd(a, d);
      tests++; if (d !== m_read(a)) begin fails++; $display("FAIL rand_read[%h]: got %h expected %h", a, d, m_read(a)); end
    end
    tests++; if (aes_iv !== {iv_m[3], iv_m[2], iv_m[1], iv_m[0]}) begin fails++; $display("FAIL rand_iv: got %h expected %h", aes_iv, {iv_m[3], iv_m[2], iv_m[1], iv_m[0]}); end
    tests++; if ({aes_decrypt, aes_enable} !== ctrl_m) begin fails++; $display("FAIL rand_ctrl: got %b%b expected %b", aes_decrypt, aes_enable, ctrl_m); end
    wr(10'h00C, 32'h0);
    wr(10'h008, 32'h7);
  endtask

  task test_key_load(input int mode, input string nm, input bit fixed);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) wr(10'(16 + 4 * i), fixed ? 32'h11111111 * (i + 1) : $urandom);
    wr(10'h004, 32'h1);
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL %s_valid_up: got %b expected 1", nm, key_valid); end
    do_load(mode);
    tests++; if (hs_n !== 4) begin fails++; $display("FAIL %s_handshakes: got %0d expected 4", nm, hs_n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (obs_w[i] !== key_m[i]) begin fails++; $display("FAIL %s_word%0d: got %h expected %h", nm, i, obs_w[i], key_m[i]); end
    end
    tests++; if (unstable_n !== 0) begin fails++; $display("FAIL %s_stable: got %0d changes expected 0", nm, unstable_n); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL %s_valid_drop: got %b expected 0", nm, key_valid); end
    if (mode == 0) begin
      tests++; if (cyc_n !== 4) begin fails++; $display("FAIL %s_consecutive: got %0d cycles expected 4", nm, cyc_n); end
    end
    tick; tick; tick;
    tests++; if (aes_sts_dbg !== m_dbg(3'd2)) begin fails++; $display("FAIL %s_wait_dbg: got %h expected %h", nm, aes_sts_dbg, m_dbg(3'd2)); end
    finish_done;
    tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL %s_done_dbg: got %h expected %h", nm, aes_sts_dbg, m_dbg(3'd0)); end
    rd(10'h008, d);
    tests++; if (d !== m_read(10'h008)) begin fails++; $display("FAIL %s_irq_sts: got %h expected %h", nm, d, m_read(10'h008)); end
    key_done = 1'b1; tick; key_done = 1'b0;
    tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL %s_stray_done: got %h expected %h", nm, aes_sts_dbg, m_dbg(3'd0)); end
    wr(10'h008, 32'h7);
  endtask

  task test_busy;
    logic [31:0] d, x;
    wr(10'h00C, 32'h2);
    key_ready = 1'b0;
    wr(10'h004, 32'h1);
    wr(10'h004, 32'h1);
    tests++; if (aes_sts_dbg[5:3] !== sts_m) begin fails++; $display("FAIL busy_cmd_err: got %b expected %b", aes_sts_dbg[5:3], sts_m); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL busy_irq_lag: got %b expected 0", irq); end
    tick;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL busy_irq_set: got %b expected 1", irq); end
    wr(10'h008, 32'h2);
    tests++; if (aes_sts_dbg[5:3] !== 3'b000 || irq !== 1'b1) begin fails++; $display("FAIL busy_w1c: got sts %b irq %b expected 000 1", aes_sts_dbg[5:3], irq); end
    tick;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL busy_irq_clr: got %b expected 0", irq); end
    wr(10'h018, 32'h0);
    tests++; if (aes_sts_dbg[5:3] !== 3'b010) begin fails++; $display("FAIL busy_key_err: got %b expected 010", aes_sts_dbg[5:3]); end
    rd(10'h018, d);
    tests++; if (d !== key_m[2]) begin fails++; $display("FAIL busy_key2_kept: got %h expected %h", d, key_m[2]); end
    x = $urandom;
    wr(10'h024, x);
    wr(10'h000, 32'h1);
    tests++; if (aes_iv !== {iv_m[3], iv_m[2], iv_m[1], iv_m[0]} || aes_enable !== 1'b1) begin fails++; $display("FAIL busy_iv_ctrl: got %h %b expected %h 1", aes_iv, aes_enable, {iv_m[3], iv_m[2], iv_m[1], iv_m[0]}); end
    do_load(0);
    tests++; if (hs_n !== 4 || obs_w[2] !== key_m[2]) begin fails++; $display("FAIL busy_load: got %0d/%h expected 4/%h", hs_n, obs_w[2], key_m[2]); end
    finish_done;
    tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL busy_done_dbg: got %h expected %h", aes_sts_dbg, m_dbg(3'd0)); end
    wr(10'h008, 32'h7);
    wr(10'h00C, 32'h0);
  endtask

  task test_timeout;
    int n;
    logic [31:0] d;
    wr(10'h004, 32'h1);
    do_load(0);
    tests++; if (hs_n !== 4) begin fails++; $display("FAIL tmo_handshakes: got %0d expected 4", hs_n); end
    n = 0;
    while (aes_sts_dbg[2:0] !== 3'd0 && n < 4 * TO) begin tick; n++; end
    m_busy = 0; sts_m[2] = 1'b1;
    tests++; if (n !== TO) begin fails++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TO); end
    tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL tmo_dbg: got %h expected %h", aes_sts_dbg, m_dbg(3'd0)); end
    rd(10'h008, d);
    tests++; if (d !== 32'h4) begin fails++; $display("FAIL tmo_irq_sts: got %h expected 4", d); end
    wr(10'h008, 32'h7);
  endtask

  task test_w1c_race;
    wr(10'h004, 32'h1);
    do_load(0);
    tick;
    reg_data_addr = 10'h008; reg_data = 32'h1; reg_data_write = 1'b1;
    finish_done;
    reg_data_write = 1'b0;
    tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL race_set_wins: got %h expected %h", aes_sts_dbg, m_dbg(3'd0)); end
    wr(10'h008, 32'h7);
  endtask

  task test_reset_mid_load;
    logic [31:0] d;
    wr(10'h010, 32'hdeadbeef);
    wr(10'h004, 32'h1);
    key_ready = 1'b1; tick; key_ready = 1'b0;
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_valid_before: got %b expected 1", key_valid); end
    reset = 1'b1; tick; reset = 1'b0;
    m_reset;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", key_valid); end
    tests++; if (aes_sts_dbg !== 32'h0) begin fails++; $display("FAIL rst_mid_dbg: got %h expected 0", aes_sts_dbg); end
    rd(10'h010, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_mid_key0: got %h expected 0", d); end
  endtask

  task test_back_to_back;
    int w;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) wr(10'(16 + 4 * i), $urandom);
      wr(10'h004, 32'h1);
      do_load(2);
      tests++; if (hs_n !== 4 || unstable_n !== 0) begin fails++; $display("FAIL b2b%0d_hs: got %0d/%0d expected 4/0", it, hs_n, unstable_n); end
      for (int i = 0; i < 4; i++) begin
        tests++; if (obs_w[i] !== key_m[i]) begin fails++; $display("FAIL b2b%0d_word%0d: got %h expected %h", it, i, obs_w[i], key_m[i]); end
      end
      w = $urandom_range(0, 5);
      for (int i = 0; i < w; i++) tick;
      finish_done;
      tests++; if (aes_sts_dbg !== m_dbg(3'd0)) begin fails++; $display("FAIL b2b%0d_dbg: got %h expected %h", it, aes_sts_dbg, m_dbg(3'd0)); end
    end
    wr(10'h008, 32'h7);
  endtask

  task test_cnt_wrap;
    int prev;
    prev = int'(cnt_m);
    for (int it = 0; it < 256; it++) begin
      wr(10'h004, 32'h1);
      do_load(0);
      finish_done;
    end
    tests++; if (aes_sts_dbg[15:8] !== cnt_m || int'(cnt_m) !== prev) begin fails++; $display("FAIL cnt_wrap: got %0d expected %0d", aes_sts_dbg[15:8], prev); end
    wr(10'h004, 32'h1);
    do_load(0);
    finish_done;
    tests++; if (aes_sts_dbg[15:8] !== cnt_m) begin fails++; $display("FAIL cnt_after_wrap: got %0d expected %0d", aes_sts_dbg[15:8], cnt_m); end
    wr(10'h008, 32'h7);
  endtask

  initial begin
    m_reset;
    test_reset;
    test_ctrl_rw;
    test_key_load(0, "load_ready", 1);
    test_key_load(1, "load_toggle", 0);
    test_busy;
    test_timeout;
    test_w1c_race;
    test_back_to_back;
    test_cnt_wrap;
    test_reset_mid_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_ctrl_regs.md
Name: aes_ctrl_regs

Overview:
- Control/status register bank downstream of the AXI-lite write path of the AES core's lite slave.
- Consumes the write strobe stream (reg_data_addr / reg_data_write / reg_data) and holds mode, key and IV registers.
- Serially loads the 128-bit key into the AES engine over a valid/ready word handshake, with a done-wait timeout.
- Raises a maskable interrupt and supplies the packed status word that drives the slave's aes_sts_dbg input.

Parameters:
- C_ADDR_WIDTH, 10, width of the register address from the write path.
- C_DATA_WIDTH, 32, register data width; only 32 is supported.
- C_TIMEOUT, 1024, cycles allowed in WAIT_DONE before abort; must be ≥2.

Ports:
- clk  in  1  core clock, shared with the lite slave.
- reset  in  1  synchronous, active-high reset.
- reg_data_addr  in  C_ADDR_WIDTH  byte address of the write.
- reg_data_write  in  1  one-cycle write strobe.
- reg_data  in  C_DATA_WIDTH  write data.
- rd_addr  in  C_ADDR_WIDTH  read address.
- rd_data  out  C_DATA_WIDTH  registered read data.
- aes_enable  out  1  CTRL[0].
- aes_decrypt  out  1  CTRL[1].
- aes_iv  out  128  {IV3,IV2,IV1,IV0}.
- key_word  out  32  key word being transferred.
- key_valid  out  1  key word valid.
- key_ready  in  1  engine accepts key word.
- key_done  in  1  engine key expansion complete (pulse).
- irq  out  1  registered interrupt.
- aes_sts_dbg  out  32  status word: {16'h0, cnt[7:0], 2'b0, irq_sts[2:0], state[2:0]}.

Behaviour:
- Register map (decode on addr[6:2]):
  - 0x00 CTRL: RW [1:0].
  - 0x04 CMD: WO, bit0 = start key load.
  - 0x08 IRQ_STS: W1C [2:0]; bit0 load done, bit1 access error, bit2 timeout.
  - 0x0C IRQ_EN: RW [2:0].
  - 0x10–0x1C KEY0..3: RW.
  - 0x20–0x2C IV0..3: RW.
  - All other addresses: writes ignored, reads return 0.
- Reset values: all registers 0, key_valid 0, irq 0, rd_data 0, FSM in IDLE, counters 0.
- Read path: rd_data <= mux(rd_addr), one-cycle latency; CMD reads return 0.
- FSM states and transitions:
  - IDLE(0): CMD write with bit0=1 -> LOAD; word index idx = 0.
  - LOAD(1): key_valid=1, key_word=KEYidx. On key_valid&key_ready: idx++; if idx was 3 -> WAIT_DONE, and key_valid drops the following cycle. key_valid must not drop without a handshake.
  - WAIT_DONE(2): key_done -> IDLE, set sts[0]. If timeout counter reaches C_TIMEOUT-1 -> IDLE, set sts[2]. Counter clears on entry.
- key_done outside WAIT_DONE is ignored.
- Busy (state≠IDLE):
  - KEY writes and CMD start are dropped and set sts[1].
  - CTRL, IV, IRQ_EN and IRQ_STS writes are still accepted.
- Simultaneous events: if a set and a W1C hit the same sts bit in one cycle, the set wins.
- irq <= |(irq_sts & irq_en), registered, so one cycle after the sts/en change.
- cnt[7:0] in the status word counts completed key loads; it wraps at 255->0 and is not cleared by sts W1C.
- Reset mid-LOAD: key_valid drops on the next edge and the FSM returns to IDLE; the engine must tolerate a partial key.

Decomposition:
- Package aes_ctrl_pkg holds:
  - register offset constants (REG_CTRL..REG_IV3);
  - FSM state encoding ST_IDLE/ST_LOAD/ST_WAIT;
  - IRQ bit indices.
- No sub-module. The key sequencer FSM stays inline; the block is roughly 200 lines.

Test Plan:
- Reset, then read all addresses -> all 0. Write CTRL=3 -> aes_enable=1, aes_decrypt=1; readback 0x3 one cycle after rd_addr.
- Write KEY0..3 = 11111111/22222222/33333333/44444444, CMD=1, key_ready held 1 -> key_word sequence 11111111, 22222222, 33333333, 44444444 on 4 consecutive cycles. key_done 3 cycles later -> IRQ_STS=1, cnt=1.
- Same load with key_ready toggling 1/0 -> key_valid and key_word stable while ready=0; still exactly 4 handshakes.
- During LOAD, write KEY2=0 and CMD=1 -> KEY2 unchanged, IRQ_STS[1]=1. With IRQ_EN=2, irq=1 on the next cycle; W1C 0x2 -> irq=0 one cycle later.
- Withhold key_done -> after C_TIMEOUT cycles FSM is IDLE, IRQ_STS=0x4, aes_sts_dbg[2:0]=0.
- W1C of bit0 in the same cycle key_done sets it -> bit0 remains 1. Reset asserted mid-LOAD -> key_valid=0 next cycle, state IDLE.
